n1_smem: RTL and testbench

N1_SMEM -- requirements
Module: N1_smem

---
 rtl/n1_smem_pkg.sv | 14 +
 rtl/n1_smem_ram.sv | 31 +++
 rtl/n1_smem.sv | 97 +++++++++
 tb/tb_n1_smem.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n1_smem_pkg.sv
// Shared definitions for the N1 stack memory: FSM state encoding and data width.
// 2'b11 is reserved and never entered by the controller.
package n1_smem_pkg;

    localparam int SMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        SMEM_IDLE = 2'b00,
        SMEM_WAIT = 2'b01,
        SMEM_RESP = 2'b10,
        SMEM_RSVD = 2'b11
    } smem_state_e;

endpackage

// File: rtl/n1_smem_ram.sv
// Stack storage: synchronous write, registered read, single shared address port.
// The address MSB selects the partition (0 = parameter stack, 1 = return stack).
module n1_smem_ram
    import n1_smem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [SMEM_DATA_W-1:0] wdata_i,
    output logic [SMEM_DATA_W-1:0] rdata_o
);

    logic [SMEM_DATA_W-1:0] mem_q [2**ADDR_W];
    logic [SMEM_DATA_W-1:0] rdata_q;

    // Write-first: a read and write of the same word on one edge returns the new data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/n1_smem.sv
// N1 stack memory: pipelined wishbone target holding the parameter and return
// stack partitions, with a configurable number of wait states per response.
module n1_smem
    import n1_smem_pkg::*;
#(
    parameter int SP_WIDTH    = 12,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   async_rst_i,
    input  logic                   sbus_cyc_i,
    input  logic                   sbus_stb_i,
    input  logic                   sbus_we_i,
    input  logic [SP_WIDTH-1:0]    sbus_adr_i,
    input  logic [SMEM_DATA_W-1:0] sbus_dat_i,
    input  logic                   sbus_tga_ps_i,
    input  logic                   sbus_tga_rs_i,
    output logic                   sbus_ack_o,
    output logic                   sbus_err_o,
    output logic                   sbus_rty_o,
    output logic                   sbus_stall_o,
    output logic [SMEM_DATA_W-1:0] sbus_dat_o,
    output logic [1:0]             prb_smem_state_o
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    smem_state_e            state_q;
    logic [3:0]             cnt_q;
    logic                   pend_valid_q;
    logic                   pend_rd_q;
    logic                   accept;
    logic                   req_valid;
    logic                   in_resp;
    logic [SMEM_DATA_W-1:0] ram_rdata;

    assign accept    = sbus_cyc_i & sbus_stb_i & ~sbus_stall_o;
    assign req_valid = (sbus_tga_ps_i ^ sbus_tga_rs_i) && ((sbus_adr_i >> DEPTH_LOG2) == '0);

    // Dropping cyc_i in RESP suppresses the response in that same cycle.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q      <= SMEM_IDLE;
            cnt_q        <= 4'd0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= 1'b0;
        end else begin
            case (state_q)
                SMEM_WAIT: begin
                    if (!sbus_cyc_i) begin
                        state_q <= SMEM_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= SMEM_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        pend_valid_q <= req_valid;
                        pend_rd_q    <= req_valid & ~sbus_we_i;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= SMEM_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q <= SMEM_RESP;
                        end
                    end else begin
                        state_q <= SMEM_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_resp          = (state_q == SMEM_RESP) & sbus_cyc_i;
    assign sbus_ack_o       = in_resp & pend_valid_q;
    assign sbus_err_o       = in_resp & ~pend_valid_q;
    assign sbus_rty_o       = 1'b0;
    assign sbus_stall_o     = (state_q == SMEM_WAIT);
    assign sbus_dat_o       = (sbus_ack_o & pend_rd_q) ? ram_rdata : '0;
    assign prb_smem_state_o = state_q;

    n1_smem_ram #(
        .ADDR_W (DEPTH_LOG2 + 1)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (accept & req_valid & sbus_we_i),
        .re_i    (accept & req_valid & ~sbus_we_i),
        .addr_i  ({sbus_tga_rs_i, sbus_adr_i[DEPTH_LOG2-1:0]}),
        .wdata_i (sbus_dat_i),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_n1_smem.sv
// Scoreboard bench for n1_smem: one instance without wait states, one with three.
// Expected responses are queued when a request is driven and popped when it returns.
module tb_n1_smem;

    typedef struct packed {
        logic        w;
        logic        p;
        logic        r;
        logic [11:0] a;
        logic [15:0] d;
    } req_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cyc0, cyc3, stb, we, ps, rs;
    logic [11:0] adr;
    logic [15:0] wdat;

    logic        ack0, err0, rty0, stall0;
    logic [15:0] dat0;
    logic [1:0]  prb0;
    logic        ack3, err3, rty3, stall3;
    logic [15:0] dat3;
    logic [1:0]  prb3;

    logic [17:0] expQ [$];
    logic [15:0] modelPs [256];
    logic [15:0] modelRs [256];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    n1_smem #(.SP_WIDTH(12), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .async_rst_i(rstN), .sbus_cyc_i(cyc0), .sbus_stb_i(stb),
        .sbus_we_i(we), .sbus_adr_i(adr), .sbus_dat_i(wdat),
        .sbus_tga_ps_i(ps), .sbus_tga_rs_i(rs), .sbus_ack_o(ack0), .sbus_err_o(err0),
        .sbus_rty_o(rty0), .sbus_stall_o(stall0), .sbus_dat_o(dat0), .prb_smem_state_o(prb0)
    );

    n1_smem #(.SP_WIDTH(12), .DEPTH_LOG2(8), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .async_rst_i(rstN), .sbus_cyc_i(cyc3), .sbus_stb_i(stb),
        .sbus_we_i(we), .sbus_adr_i(adr), .sbus_dat_i(wdat),
        .sbus_tga_ps_i(ps), .sbus_tga_rs_i(rs), .sbus_ack_o(ack3), .sbus_err_o(err3),
        .sbus_rty_o(rty3), .sbus_stall_o(stall3), .sbus_dat_o(dat3), .prb_smem_state_o(prb3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stb = 1'b0; we = 1'b0; ps = 1'b0; rs = 1'b0; adr = '0; wdat = '0;
    endtask

    // Drives one request and queues its expected {ack, err, dat} from the memory model.
    task automatic applyStimulus(input req_t rq);
        logic valid;
        stb = 1'b1; we = rq.w; ps = rq.p; rs = rq.r; adr = rq.a; wdat = rq.d;
        valid = (rq.p ^ rq.r) && (rq.a < 12'h100);
        if (!valid) begin
            expQ.push_back({2'b01, 16'h0000});
        end else if (rq.w) begin
            if (rq.p) modelPs[rq.a[7:0]] = rq.d;
            else      modelRs[rq.a[7:0]] = rq.d;
            expQ.push_back({2'b10, 16'h0000});
        end else begin
            expQ.push_back({2'b10, rq.p ? modelPs[rq.a[7:0]] : modelRs[rq.a[7:0]]});
        end
    endtask

    task automatic wait_resp3(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack3 || err3) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0;
        idle();
        step();
        @(negedge clk);
        tests++;
        if ({ack0, err0, stall0, rty0, dat0, prb0} !== 22'h0) begin
            fails++; $display("[TB] FAIL reset_dut0 got %h expected 0", {ack0, err0, stall0, rty0, dat0, prb0});
        end
        tests++;
        if ({ack3, err3, stall3, rty3, dat3, prb3} !== 22'h0) begin
            fails++; $display("[TB] FAIL reset_dut3 got %h expected 0", {ack3, err3, stall3, rty3, dat3, prb3});
        end
        rstN = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if ({ack0, err0, stall0, dat0, prb0, ack3, err3, stall3, dat3, prb3} !== 42'h0) begin
            fails++; $display("[TB] FAIL idle_after_reset got %h expected 0",
                {ack0, err0, stall0, dat0, prb0, ack3, err3, stall3, dat3, prb3});
        end
        step();
    endtask

    task automatic test_ps_write_read();
        logic [17:0] got, expv;
        cyc0 = 1'b1;
        applyStimulus({1'b1, 1'b1, 1'b0, 12'h005, 16'h1234});
        step(); idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL ps_write_resp got %h expected %h", got, expv); end
        step();
        @(negedge clk);
        tests++;
        if ({ack0, err0, dat0} !== 18'h0) begin
            fails++; $display("[TB] FAIL ps_write_pulse got %h expected 0", {ack0, err0, dat0});
        end
        step();
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h005, 16'h0000});
        step(); idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL ps_read_resp got %h expected %h", got, expv); end
        step();
        cyc0 = 1'b0;
    endtask

    task automatic test_partitions();
        req_t        reqs [6];
        logic [17:0] got, expv;
        reqs = '{{1'b1, 1'b0, 1'b1, 12'h005, 16'hBEEF}, {1'b0, 1'b1, 1'b0, 12'h005, 16'h0000},
                 {1'b0, 1'b0, 1'b1, 12'h005, 16'h0000}, {1'b1, 1'b0, 1'b1, 12'h0FF, 16'h0F0F},
                 {1'b0, 1'b0, 1'b1, 12'h0FF, 16'h0000}, {1'b0, 1'b1, 1'b0, 12'h005, 16'h0000}};
        cyc0 = 1'b1;
        foreach (reqs[i]) begin
            applyStimulus(reqs[i]);
            if (i > 0) begin
                @(negedge clk);
                got = {ack0, err0, dat0}; expv = expQ.pop_front();
                tests++;
                if (got !== expv) begin fails++; $display("[TB] FAIL partition[%0d] got %h expected %h", i - 1, got, expv); end
            end
            step();
        end
        idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL partition_last got %h expected %h", got, expv); end
        step();
        cyc0 = 1'b0;
    endtask

    task automatic test_errors();
        req_t        reqs [8];
        logic [17:0] got, expv;
        reqs = '{{1'b0, 1'b1, 1'b0, 12'h100, 16'h0000}, {1'b1, 1'b1, 1'b1, 12'h005, 16'hDEAD},
                 {1'b1, 1'b0, 1'b0, 12'h005, 16'hDEAD}, {1'b1, 1'b1, 1'b0, 12'h105, 16'h9999},
                 {1'b0, 1'b1, 1'b0, 12'h005, 16'h0000}, {1'b0, 1'b0, 1'b1, 12'h005, 16'h0000},
                 {1'b0, 1'b1, 1'b0, 12'hFFF, 16'h0000}, {1'b1, 1'b0, 1'b1, 12'h800, 16'h5555}};
        cyc0 = 1'b1;
        foreach (reqs[i]) begin
            applyStimulus(reqs[i]);
            if (i > 0) begin
                @(negedge clk);
                got = {ack0, err0, dat0}; expv = expQ.pop_front();
                tests++;
                if (got !== expv) begin fails++; $display("[TB] FAIL error_case[%0d] got %h expected %h", i - 1, got, expv); end
            end
            step();
        end
        applyStimulus({1'b0, 1'b0, 1'b1, 12'h000, 16'h0000});
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL error_case_last got %h expected %h", got, expv); end
        step(); idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL rs_word0_untouched got %h expected %h", got, expv); end
        step();
        cyc0 = 1'b0;
    endtask

    task automatic test_stb_without_cyc();
        logic [17:0] got, expv;
        bit          anyResp = 1'b0;
        cyc0 = 1'b0; cyc3 = 1'b0;
        stb = 1'b1; we = 1'b1; ps = 1'b1; rs = 1'b0; adr = 12'h005; wdat = 16'h0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack0 || err0 || stall0 || ack3 || err3 || stall3) anyResp = 1'b1;
            step();
        end
        tests++;
        if (anyResp) begin fails++; $display("[TB] FAIL stb_without_cyc got a response expected none"); end
        idle();
        cyc0 = 1'b1;
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h005, 16'h0000});
        step(); idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL stb_without_cyc_mem got %h expected %h", got, expv); end
        step();
        cyc0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_t        reqs [12];
        logic [17:0] got, expv;
        for (int i = 0; i < 12; i++) begin
            reqs[i].w = (i < 6);
            reqs[i].p = ((i % 6) % 2 == 0);
            reqs[i].r = ((i % 6) % 2 != 0) || (i == 9);
            reqs[i].a = 12'(12'h040 + (i % 6));
            reqs[i].d = 16'($urandom);
        end
        cyc0 = 1'b1;
        foreach (reqs[i]) begin
            applyStimulus(reqs[i]);
            if (i > 0) begin
                @(negedge clk);
                got = {ack0, err0, dat0}; expv = expQ.pop_front();
                tests++;
                if (got !== expv) begin fails++; $display("[TB] FAIL back_to_back[%0d] got %h expected %h", i - 1, got, expv); end
                tests++;
                if (stall0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_stall[%0d] got %b expected 0", i - 1, stall0); end
            end
            step();
        end
        idle();
        @(negedge clk);
        got = {ack0, err0, dat0}; expv = expQ.pop_front();
        tests++;
        if (got !== expv) begin fails++; $display("[TB] FAIL back_to_back_last got %h expected %h", got, expv); end
        step();
        cyc0 = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [17:0] got, expv;
        logic [2:0]  probeExp [5];
        bit          seen;
        probeExp = '{3'b000, 3'b011, 3'b011, 3'b011, 3'b100};
        cyc3 = 1'b1;
        applyStimulus({1'b1, 1'b1, 1'b0, 12'h010, 16'hA5A5});
        step(); idle();
        wait_resp3(seen);
        got = {ack3, err3, dat3}; expv = expQ.pop_front();
        tests++;
        if (!seen || got !== expv) begin fails++; $display("[TB] FAIL ws_write_resp got %h expected %h seen %0b", got, expv, seen); end
        step();
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h010, 16'h0000});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if ({prb3, stall3} !== probeExp[c]) begin
                fails++; $display("[TB] FAIL ws_probe[%0d] got %b expected %b", c, {prb3, stall3}, probeExp[c]);
            end
            got = {ack3, err3, dat3};
            expv = (c == 4) ? expQ.pop_front() : 18'h0;
            tests++;
            if (got !== expv) begin fails++; $display("[TB] FAIL ws_resp[%0d] got %h expected %h", c, got, expv); end
            step();
            if (c == 0) idle();
        end
        @(negedge clk);
        tests++;
        if ({ack3, err3, prb3} !== 4'b0000) begin
            fails++; $display("[TB] FAIL ws_pulse_end got %b expected 0000", {ack3, err3, prb3});
        end
        step();
    endtask

    task automatic test_abort();
        logic [17:0] got, expv;
        bit          seen;
        bit          anyResp = 1'b0;
        cyc3 = 1'b1;
        applyStimulus({1'b1, 1'b1, 1'b0, 12'h020, 16'h7777});
        expv = expQ.pop_back();
        step(); idle();
        @(negedge clk);
        tests++;
        if (prb3 !== 2'b01) begin fails++; $display("[TB] FAIL abort_cycle1 probe got %b expected 01", prb3); end
        step();
        cyc3 = 1'b0;
        @(negedge clk);
        tests++;
        if (prb3 !== 2'b01) begin fails++; $display("[TB] FAIL abort_cycle2 probe got %b expected 01", prb3); end
        step();
        @(negedge clk);
        tests++;
        if (prb3 !== 2'b00) begin fails++; $display("[TB] FAIL abort_cycle3 probe got %b expected 00", prb3); end
        cyc3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            if (ack3 || err3) anyResp = 1'b1;
        end
        tests++;
        if (anyResp) begin fails++; $display("[TB] FAIL abort_no_resp got a response expected none"); end
        step();
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h020, 16'h0000});
        step(); idle();
        wait_resp3(seen);
        got = {ack3, err3, dat3}; expv = expQ.pop_front();
        tests++;
        if (!seen || got !== expv) begin fails++; $display("[TB] FAIL abort_write_kept got %h expected %h seen %0b", got, expv, seen); end
        step();
    endtask

    task automatic test_reset_midwait();
        logic [17:0] got, expv;
        bit          seen;
        bit          anyResp = 1'b0;
        cyc3 = 1'b1;
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h010, 16'h0000});
        expv = expQ.pop_back();
        step(); idle();
        step();
        @(negedge clk);
        tests++;
        if ({prb3, stall3} !== 3'b011) begin fails++; $display("[TB] FAIL midwait_pre got %b expected 011", {prb3, stall3}); end
        #2 rstN = 1'b0;
        #1;
        tests++;
        if ({ack3, err3, stall3, rty3, dat3, prb3} !== 22'h0) begin
            fails++; $display("[TB] FAIL midwait_reset got %h expected 0", {ack3, err3, stall3, rty3, dat3, prb3});
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (ack3 || err3) anyResp = 1'b1;
        end
        tests++;
        if (anyResp) begin fails++; $display("[TB] FAIL midwait_dropped got a response expected none"); end
        step();
        applyStimulus({1'b0, 1'b1, 1'b0, 12'h010, 16'h0000});
        step(); idle();
        wait_resp3(seen);
        got = {ack3, err3, dat3}; expv = expQ.pop_front();
        tests++;
        if (!seen || got !== expv) begin fails++; $display("[TB] FAIL midwait_mem_kept got %h expected %h seen %0b", got, expv, seen); end
        step();
        cyc3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ps_write_read();
        test_partitions();
        test_errors();
        test_stb_without_cyc();
        test_back_to_back();
        test_wait_states();
        test_abort();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

endmodule
